pc_fetch_sequencer: RTL
=======================

# pc_fetch_sequencer

Owns the architectural PC and sequences instruction fetch for the pipelined WISC core. Drives the instruction-memory request, advances the PC by 2 on each accepted fetch, holds it on hazard stalls, redirects it on a taken branch resolved in decode, and parks the front end on HLT. Sits between the branch/PC-control logic in ID, the hazard unit, instruction memory and the IF/ID pipeline register.

## Interface
- PC_RESET, 16'h0000, PC value loaded on reset
- PC_STEP, 16'h0002, sequential increment
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: IF/ID cannot accept a new instruction this cycle
- br_taken  in  1  branch resolved taken in ID this cycle
- br_target  in  16  redirect address from PC control
- imem_ack  in  1  instruction for imem_addr is available this cycle; may rise the same cycle as imem_req or any later cycle
- halt_dec  in  1  instruction on the imem data bus has opcode HLT (qualified by imem_ack)
- imem_req  out  1  fetch request
- imem_addr  out  16  fetch address (= pc)
- pc  out  16  current PC register
- pc_plus2  out  16  pc + 2, passed into IF/ID for branch offset computation
- if_valid  out  1  load IF/ID with a valid instruction this cycle
- flush  out  1  clear IF/ID this cycle (wrong-path kill)
- halted  out  1  front end parked on HLT

## Operation
- States: FETCH (request outstanding, no wait yet), WAIT (request outstanding ≥1 cycle without ack), HALT.
- Reset (rst_n low, immediately): pc=PC_RESET, state=FETCH, all 1-bit outputs 0. imem_req is 0 while rst_n low, 1 from the first cycle after release.
- imem_req = 1 in FETCH and WAIT, 0 in HALT. imem_addr = pc always.
- Per-edge priority, highest first:
  - br_taken (any state): pc <= {br_target[15:1],1'b0}; state <= FETCH; flush=1, if_valid=0 this cycle. Clears HALT (the HLT was wrong-path). Any ack this cycle is discarded.
  - stall: pc holds; if_valid=0; ack this cycle is discarded (refetched next cycle); FETCH/WAIT unchanged except FETCH->WAIT if no ack.
  - imem_ack & halt_dec (FETCH/WAIT): if_valid=1 (HLT enters pipeline), pc holds, state <= HALT.
  - imem_ack (FETCH/WAIT): if_valid=1, pc <= pc_plus2, state <= FETCH.
  - no ack: FETCH->WAIT, WAIT->WAIT, pc holds.
  - HALT with no br_taken: stays HALT; if_valid=0; halted=1; imem_ack/halt_dec ignored.
- Combinational: if_valid = imem_ack & (state != HALT) & ~stall & ~br_taken; flush = br_taken; halted = (state == HALT).
- Arithmetic: pc_plus2 is 16-bit modulo; 16'hFFFE + 2 = 16'h0000, no overflow flag. br_target bit 0 is ignored.
- Memory contract: while imem_req is high, memory samples imem_addr every cycle; imem_ack always refers to the current imem_addr, so changing pc mid-WAIT aborts the old fetch without a drop counter.

## Timing
- Zero-wait fetch: one instruction per cycle, pc advances every edge with ack.
- N-wait fetch: N cycles in WAIT with pc stable, then one if_valid cycle.
- Redirect latency: target appears on imem_addr the cycle after br_taken; exactly one flush cycle.
- HLT: if_valid high one cycle, halted high from next cycle, imem_req low from next cycle.
- Simultaneous br_taken + stall + ack: redirect wins; no instruction loaded.
- Reset asserted mid-WAIT: outputs go to reset values immediately, no edge required; outstanding fetch abandoned.

## Structure
- Shared package wisc_pkg: fetch state enum (FETCH, WAIT, HALT), PC_RESET, PC_STEP, OPC_HLT = 4'hF.
- Sub-module: reuse adder_16bit for pc + PC_STEP (Sub=0, flags unconnected); PC register and FSM live in this block.

## Test plan
- Reset release, imem_ack tied 1 -> imem_addr 0x0000, 0x0002, 0x0004 on consecutive cycles, if_valid=1 each cycle, flush=0.
- ack delayed 3 cycles at pc=0x0010 -> pc stays 0x0010 for 3 cycles in WAIT, if_valid pulses once, next pc 0x0012.
- stall held 2 cycles with ack=1 at pc=0x0020 -> pc stays 0x0020, if_valid=0 both cycles; stall drop -> if_valid=1, pc 0x0022.
- br_taken with br_target=0x0101 while in WAIT at 0x0040 -> flush=1 that cycle, next imem_addr 0x0100, old ack ignored.
- HLT fetched at 0x0030 -> if_valid=1 once, halted=1 and imem_req=0 afterward, pc holds 0x0030; later br_taken to 0x0050 -> halted=0, fetch resumes at 0x0050.
- pc=0xFFFE with ack -> pc_plus2=0x0000, next pc 0x0000; rst_n pulsed low mid-WAIT -> pc=0x0000, if_valid=0 asynchronously.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC core definitions: fetch FSM encoding, PC constants and opcodes.
package wisc_pkg;

   localparam int unsigned PC_W = 16;

   localparam logic [PC_W-1:0] PC_RESET = 16'h0000;
   localparam logic [PC_W-1:0] PC_STEP  = 16'h0002;
   localparam logic [3:0]      OPC_HLT  = 4'hF;

   typedef enum logic [1:0] {
      FS_FETCH = 2'd0,
      FS_WAIT  = 2'd1,
      FS_HALT  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/adder_16bit.sv
// 16-bit modulo adder/subtractor; sub_i selects a - b.
module adder_16bit
   import wisc_pkg::*;
(
   input  logic [PC_W-1:0] a_i,
   input  logic [PC_W-1:0] b_i,
   input  logic            sub_i,
   output logic [PC_W-1:0] sum_o
);

   logic [PC_W-1:0] b_eff;

   always_comb begin
      b_eff = sub_i ? ~b_i : b_i;
      sum_o = a_i + b_eff + PC_W'(sub_i);
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Owns the architectural PC and sequences instruction fetch: advance on ack,
// hold on stall, redirect on taken branch, park on HLT.
module pc_fetch_sequencer
   import wisc_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            imem_ack,
   input  logic            halt_dec,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus2,
   output logic            if_valid,
   output logic            flush,
   output logic            halted
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pc_inc;

   adder_16bit u_pc_adder (
      .a_i   (pc_q),
      .b_i   (PC_STEP),
      .sub_i (1'b0),
      .sum_o (pc_inc)
   );

   // State and PC registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FS_FETCH;
         pc_q    <= PC_RESET;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next state; a redirect always wins, and any ack under redirect/stall is dropped
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (br_taken) begin
         pc_d    = {br_target[PC_W-1:1], 1'b0};
         state_d = FS_FETCH;
      end else begin
         unique case (state_q)
            FS_FETCH, FS_WAIT: begin
               if (stall) begin
                  if (!imem_ack) state_d = FS_WAIT;
               end else if (imem_ack && halt_dec) begin
                  state_d = FS_HALT;
               end else if (imem_ack) begin
                  pc_d    = pc_inc;
                  state_d = FS_FETCH;
               end else begin
                  state_d = FS_WAIT;
               end
            end
            FS_HALT: state_d = FS_HALT;
            default: state_d = FS_FETCH;
         endcase
      end
   end

   // Outputs; 1-bit outputs are forced low while reset is asserted
   always_comb begin
      imem_req  = 1'b0;
      if_valid  = 1'b0;
      flush     = 1'b0;
      halted    = 1'b0;
      imem_addr = pc_q;
      pc        = pc_q;
      pc_plus2  = pc_inc;
      if (rst_n) begin
         imem_req = (state_q != FS_HALT);
         if_valid = imem_ack && (state_q != FS_HALT) && !stall && !br_taken;
         flush    = br_taken;
         halted   = (state_q == FS_HALT);
      end
   end

endmodule
